// File: rtl/aes_mem_pkg.sv
// Shared types and constants for the AES memory-side DMA blocks.
package aes_mem_pkg;

    localparam int unsigned WORD_BYTES = 8;
    localparam int unsigned BLK_WORDS  = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WR_LO = 3'd2,
        WR_HI = 3'd3,
        DONE  = 3'd4
    } wb_state_t;

endpackage

// File: rtl/wr_addr_counter.sv
// Destination address and byte-count registers for the writeback DMA, stepping one SRAM word at a time.
module wr_addr_counter
    import aes_mem_pkg::*;
#(
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 load,
    input  logic                 inc,
    input  logic [ADDR_BITS-1:0] load_addr,
    input  logic [ADDR_BITS-1:0] load_len,
    output logic [ADDR_BITS-1:0] addr,
    output logic [ADDR_BITS-1:0] addr_inc,
    output logic [ADDR_BITS-1:0] cnt,
    output logic                 cnt_inc_ge_len
);

    localparam logic [ADDR_BITS-1:0] STEP = ADDR_BITS'(WORD_BYTES);

    logic [ADDR_BITS-1:0] addr_r;
    logic [ADDR_BITS-1:0] cnt_r;
    logic [ADDR_BITS-1:0] len_r;

    // Address, byte count and length registers: load on start, step by one word on each accepted write
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            addr_r <= {ADDR_BITS{1'b0}};
            cnt_r  <= {ADDR_BITS{1'b0}};
            len_r  <= {ADDR_BITS{1'b0}};
        end else if (load) begin
            addr_r <= load_addr;
            cnt_r  <= {ADDR_BITS{1'b0}};
            len_r  <= load_len;
        end else if (inc) begin
            addr_r <= addr_r + STEP;
            cnt_r  <= cnt_r + STEP;
        end else begin
            addr_r <= addr_r;
            cnt_r  <= cnt_r;
            len_r  <= len_r;
        end
    end

    assign addr     = addr_r;
    assign addr_inc = addr_r + STEP;
    assign cnt      = cnt_r;
    // Compare against the count as it will be after the write being accepted now
    assign cnt_inc_ge_len = ((cnt_r + STEP) >= len_r);

endmodule

// File: rtl/block_writeback.sv
// Write-side DMA: accepts 128-bit cipher blocks and writes each to SRAM as two ascending 64-bit words.
module block_writeback
    import aes_mem_pkg::*;
#(
    parameter int ADDR_BITS = 16,
    parameter int WORD_BITS = 64,
    parameter int BLK_BITS  = 128
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] dst_addr,
    input  logic [ADDR_BITS-1:0] len,
    input  logic                 blk_valid,
    input  logic [BLK_BITS-1:0]  blk_data,
    output logic                 blk_ready,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WORD_BITS-1:0] mem_wdata,
    input  logic                 mem_wait,
    output logic [ADDR_BITS-1:0] bytes_written,
    output logic                 busy,
    output logic                 done
);

    wb_state_t            state_r;
    logic [WORD_BITS-1:0] lo_buf_r;
    logic                 blk_ready_r;
    logic                 mem_we_r;
    logic [ADDR_BITS-1:0] mem_addr_r;
    logic [WORD_BITS-1:0] mem_wdata_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 load_s;
    logic                 inc_s;
    logic [ADDR_BITS-1:0] addr_s;
    logic [ADDR_BITS-1:0] addr_inc_s;
    logic [ADDR_BITS-1:0] cnt_s;
    logic                 last_s;

    assign load_s = (state_r == IDLE) && start;
    assign inc_s  = ((state_r == WR_LO) || (state_r == WR_HI)) && mem_we_r && !mem_wait;

    wr_addr_counter #(.ADDR_BITS(ADDR_BITS)) u_cnt (
        .clk            (clk),
        .n_rst          (n_rst),
        .load           (load_s),
        .inc            (inc_s),
        .load_addr      (dst_addr),
        .load_len       (len),
        .addr           (addr_s),
        .addr_inc       (addr_inc_s),
        .cnt            (cnt_s),
        .cnt_inc_ge_len (last_s)
    );

    // Transfer FSM with registered handshake and SRAM outputs; the high word goes straight out, the low word is buffered
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r     <= IDLE;
            lo_buf_r    <= {WORD_BITS{1'b0}};
            blk_ready_r <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_BITS{1'b0}};
            mem_wdata_r <= {WORD_BITS{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        busy_r <= 1'b1;
                        if (len == {ADDR_BITS{1'b0}}) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r     <= RECV;
                            blk_ready_r <= 1'b1;
                        end
                    end
                end
                RECV: begin
                    if (blk_valid && blk_ready_r) begin
                        state_r     <= WR_LO;
                        lo_buf_r    <= blk_data[WORD_BITS-1:0];
                        blk_ready_r <= 1'b0;
                        mem_we_r    <= 1'b1;
                        mem_addr_r  <= addr_s;
                        mem_wdata_r <= blk_data[BLK_BITS-1:WORD_BITS];
                    end
                end
                WR_LO: begin
                    if (!mem_wait) begin
                        state_r     <= WR_HI;
                        mem_addr_r  <= addr_inc_s;
                        mem_wdata_r <= lo_buf_r;
                    end
                end
                WR_HI: begin
                    if (!mem_wait) begin
                        mem_we_r <= 1'b0;
                        if (last_s) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r     <= RECV;
                            blk_ready_r <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    blk_ready_r <= 1'b0;
                    mem_we_r    <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign blk_ready     = blk_ready_r;
    assign mem_we        = mem_we_r;
    assign mem_addr      = mem_addr_r;
    assign mem_wdata     = mem_wdata_r;
    assign bytes_written = cnt_s;
    assign busy          = busy_r;
    assign done          = done_r;

endmodule

// File: tb/tb_block_writeback.sv
// Self-checking bench for block_writeback: table-driven transfers plus reset, len=0 and start-while-busy sequences.
module tb_block_writeback;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         start;
    logic [15:0]  dst_addr;
    logic [15:0]  len;
    logic         blk_valid;
    logic [127:0] blk_data;
    logic         blk_ready;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [63:0]  mem_wdata;
    logic         mem_wait = 1'b0;
    logic [15:0]  bytes_written;
    logic         busy;
    logic         done;

    block_writeback #(.ADDR_BITS(16), .WORD_BITS(64), .BLK_BITS(128)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .start         (start),
        .dst_addr      (dst_addr),
        .len           (len),
        .blk_valid     (blk_valid),
        .blk_data      (blk_data),
        .blk_ready     (blk_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wait      (mem_wait),
        .bytes_written (bytes_written),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [63:0] data;
        bit          hi;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         wr_e;
    bit          stall_en    = 1'b0;
    int          stall_cnt   = 0;
    int          stall_total = 0;
    int          done_cnt    = 0;
    int          wr_seen     = 0;
    bit          ready_seen  = 1'b0;
    bit          prev_stall  = 1'b0;
    bit          prev_done   = 1'b0;
    logic [15:0] prev_addr;
    logic [63:0] prev_data;

    // Monitor on the falling edge: drives mem_wait stalls and scores every accepted write
    always @(negedge clk) begin
        if (!n_rst) begin
            mem_wait   = 1'b0;
            prev_stall = 1'b0;
            prev_done  = 1'b0;
            stall_cnt  = 0;
        end else begin
            if (prev_stall) begin
                check("stall_we", mem_we, 1'b1);
                check("stall_addr", mem_addr, prev_addr);
                check("stall_data", mem_wdata, prev_data);
            end
            if (done) begin
                done_cnt++;
                check("done_width", prev_done, 1'b0);
            end
            prev_done = done;
            if (blk_ready) ready_seen = 1'b1;
            mem_wait = 1'b0;
            if (mem_we && stall_en && exp_q.size() > 0 && exp_q[0].hi && stall_cnt < 3) begin
                mem_wait = 1'b1;
                stall_cnt++;
                stall_total++;
            end
            prev_stall = mem_we && mem_wait;
            prev_addr  = mem_addr;
            prev_data  = mem_wdata;
            if (mem_we && !mem_wait) begin
                wr_seen++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: write at %0h, expected no write", mem_addr);
                end else begin
                    wr_e = exp_q.pop_front();
                    check("wr_addr", mem_addr, wr_e.addr);
                    check("wr_data", mem_wdata, wr_e.data);
                    if (wr_e.hi) stall_cnt = 0;
                end
            end
        end
    end

    task automatic push_block(input logic [15:0] base, input logic [127:0] blk);
        wr_t e;
        e.addr = base;         e.data = blk[127:64]; e.hi = 1'b0; exp_q.push_back(e);
        e.addr = base + 16'd8; e.data = blk[63:0];   e.hi = 1'b1; exp_q.push_back(e);
    endtask

    task automatic run_xfer(input string tag, input logic [15:0] dst, input logic [15:0] ln,
                            input int nblk, input bit stall, input logic [127:0] seed,
                            input logic [15:0] exp_bw);
        int           d0;
        int           c;
        bit           ok;
        logic [127:0] blk;
        d0          = done_cnt;
        stall_en    = stall;
        stall_total = 0;
        start       = 1'b1;
        dst_addr    = dst;
        len         = ln;
        @(posedge clk); #2;
        start = 1'b0;
        for (int b = 0; b < nblk; b++) begin
            blk = seed ^ {4{32'(b) * 32'h01010101}};
            push_block(dst + 16'(16 * b), blk);
            blk_valid = 1'b1;
            blk_data  = blk;
            ok = 1'b0;
            for (int k = 0; k < 50 && !ok; k++) begin
                if (blk_ready) ok = 1'b1;
                @(posedge clk); #2;
            end
            blk_valid = 1'b0;
            check({tag, "_accept"}, ok, 1'b1);
        end
        c = 0;
        while (done_cnt == d0 && c < 100) begin
            @(posedge clk); #2;
            c++;
        end
        check({tag, "_busy_end"}, busy, 1'b0);
        check({tag, "_bytes"}, bytes_written, exp_bw);
        repeat (2) begin @(posedge clk); #2; end
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        if (stall) check({tag, "_stalls"}, stall_total, 3 * nblk);
        stall_en = 1'b0;
    endtask

    typedef struct {
        string        tag;
        logic [15:0]  dst;
        logic [15:0]  ln;
        int           nblk;
        bit           stall;
        logic [127:0] seed;
        logic [15:0]  bw;
    } vec_t;

    vec_t vecs[4];
    int   w0;
    int   d0;

    initial begin
        vecs[0] = '{"single",   16'h0040, 16'd16, 1, 1'b0, 128'h00112233445566778899AABBCCDDEEFF, 16'd16};
        vecs[1] = '{"stall3",   16'h0040, 16'd48, 3, 1'b1, 128'hDEADBEEF0123456789ABCDEFCAFEF00D, 16'd48};
        vecs[2] = '{"wrap",     16'hFFF8, 16'd10, 1, 1'b0, 128'hA5A5A5A55A5A5A5A0F0F0F0FF0F0F0F0, 16'd16};
        vecs[3] = '{"roundup",  16'h1230, 16'd40, 3, 1'b0, 128'h13579BDF2468ACE0FEDCBA9876543210, 16'd48};

        n_rst     = 1'b0;
        start     = 1'b0;
        dst_addr  = 16'h0000;
        len       = 16'h0000;
        blk_valid = 1'b0;
        blk_data  = 128'h0;
        #1;
        check("rst_outputs", {blk_ready, mem_we, mem_addr, mem_wdata, bytes_written, busy, done}, 0);
        repeat (2) @(posedge clk);
        #2 n_rst = 1'b1;
        @(posedge clk); #2;

        for (int i = 0; i < 4; i++)
            run_xfer(vecs[i].tag, vecs[i].dst, vecs[i].ln, vecs[i].nblk, vecs[i].stall, vecs[i].seed, vecs[i].bw);

        // len = 0: straight to DONE with no writes and no ready
        ready_seen = 1'b0;
        w0 = wr_seen;
        d0 = done_cnt;
        start = 1'b1; dst_addr = 16'h0500; len = 16'h0000;
        @(posedge clk); #2;
        start = 1'b0;
        check("len0_done", done, 1'b1);
        check("len0_busy", busy, 1'b1);
        @(posedge clk); #2;
        check("len0_done_off", done, 1'b0);
        check("len0_idle", busy, 1'b0);
        check("len0_no_write", wr_seen - w0, 0);
        check("len0_no_ready", ready_seen, 1'b0);
        check("len0_pulses", done_cnt - d0, 1);
        check("len0_bytes", bytes_written, 16'h0000);

        // start while busy is ignored; reset between WR_LO and WR_HI abandons the transfer
        start = 1'b1; dst_addr = 16'h0100; len = 16'd32;
        @(posedge clk); #2;
        start = 1'b0;
        check("seq_ready", blk_ready, 1'b1);
        push_block(16'h0100, 128'h0102030405060708090A0B0C0D0E0F10);
        blk_valid = 1'b1;
        blk_data  = 128'h0102030405060708090A0B0C0D0E0F10;
        @(posedge clk); #2;
        blk_valid = 1'b0;
        check("seq_lo_we", mem_we, 1'b1);
        check("seq_lo_addr", mem_addr, 16'h0100);
        start = 1'b1; dst_addr = 16'h2000; len = 16'h0000;
        @(posedge clk); #2;
        start = 1'b0;
        check("seq_hi_addr", mem_addr, 16'h0108);
        check("seq_hi_bytes", bytes_written, 16'd8);
        check("seq_hi_busy", busy, 1'b1);
        n_rst = 1'b0;
        #1;
        check("seq_rst_outputs", {blk_ready, mem_we, mem_addr, mem_wdata, bytes_written, busy, done}, 0);
        exp_q.delete();
        @(posedge clk); #2;
        n_rst = 1'b1;
        @(posedge clk); #2;
        check("seq_rst_idle", busy, 1'b0);
        run_xfer("after_rst", 16'h0040, 16'd16, 1, 1'b0, 128'hFFEEDDCCBBAA99887766554433221100, 16'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
